// File: rtl/spi_iap_pkg.sv
// Shared definitions for the IAP programmer SPI receive path.
package spi_iap_pkg;

  localparam int WORD_W_DEF      = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall pulses
// derived from the last synchroniser stage and one extra registered copy.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw input through the synchroniser chain and keep one delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_rx_framer.sv
// SPI mode-0 slave front end: oversamples SCK/CS/MOSI in the PCLK domain,
// deserialises MSB-first words into a one-word hold register that feeds the
// word FIFO, and shifts a status word out on MISO in parallel.
module spi_rx_framer
  import spi_iap_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [WORD_W-1:0] tx_word,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [WORD_W-1:0] fifo_wr_data,
  output logic [15:0]       word_cnt,
  output logic              frame_done,
  output logic              rx_overflow,
  output logic              frame_err,
  input  logic              err_clr,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);

  // Synchronised levels and edge pulses
  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(PCLK), .rst(PRESET), .din(spi_sck),
    .dout(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(PCLK), .rst(PRESET), .din(spi_cs_n),
    .dout(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(PCLK), .rst(PRESET), .din(spi_mosi),
    .dout(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_e state_q, state_d;

  // Control strobes decoded from state and edges
  logic start_frame, end_frame, bit_rise, bit_fall, word_done, partial, push;

  // Datapath registers
  logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [WORD_W-2:0] rx_shift_q,   rx_shift_d;
  logic [WORD_W-1:0] tx_shift_q,   tx_shift_d;
  logic              miso_q,       miso_d;
  logic [WORD_W-1:0] hold_reg_q,   hold_reg_d;
  logic              hold_valid_q, hold_valid_d;
  logic [15:0]       word_cnt_q,   word_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              ovf_q,        ovf_d;
  logic              ferr_q,       ferr_d;

  // FSM state register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a frame spans the synchronised CS-low window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: SCK edges only count inside a frame.
  always_comb begin
    start_frame = (state_q == IDLE)  && cs_fall;
    end_frame   = (state_q == SHIFT) && cs_rise;
    bit_rise    = (state_q == SHIFT) && sck_rise;
    bit_fall    = (state_q == SHIFT) && sck_fall;
    word_done   = bit_rise && (bit_cnt_q == LAST_BIT);
    // A rise that does not complete a word still leaves a partial word behind.
    partial     = end_frame && !word_done && (bit_rise || (bit_cnt_q != '0));
    push        = hold_valid_q && !fifo_full;
  end

  // Datapath next state: shifting, word hand-off, push accounting and error flags.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    miso_d       = miso_q;
    hold_reg_d   = hold_reg_q;
    hold_valid_d = hold_valid_q;
    word_cnt_d   = word_cnt_q;
    frame_done_d = end_frame;
    ovf_d        = ovf_q;
    ferr_d       = ferr_q;

    // MSB goes out right away so it is valid before the first SCK rise.
    if (start_frame) begin
      tx_shift_d = {tx_word[WORD_W-2:0], 1'b0};
      miso_d     = tx_word[WORD_W-1];
      bit_cnt_d  = '0;
    end

    if (bit_rise) begin
      rx_shift_d = {rx_shift_q[WORD_W-3:0], mosi_sync};
      bit_cnt_d  = bit_cnt_q + 1'b1;
    end

    if (bit_fall) begin
      miso_d     = tx_shift_q[WORD_W-1];
      tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
    end

    if (push) begin
      hold_valid_d = 1'b0;
      if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
    end

    if (start_frame) word_cnt_d = '0;

    // Completed word: either take the hold slot or, if it is occupied, drop it.
    if (word_done) begin
      bit_cnt_d  = '0;
      tx_shift_d = tx_word;
      if (hold_valid_q) begin
        ovf_d = 1'b1;
      end else begin
        hold_reg_d   = {rx_shift_q, mosi_sync};
        hold_valid_d = 1'b1;
      end
    end

    // A partial word at CS release is simply forgotten.
    if (end_frame) bit_cnt_d = '0;

    // Clear first so that a same-cycle error event wins.
    if (err_clr) begin
      if (!(word_done && hold_valid_q)) ovf_d = 1'b0;
      if (!partial)                     ferr_d = 1'b0;
    end
    if (partial) ferr_d = 1'b1;
  end

  // Datapath registers; reset drops any held word.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      miso_q       <= 1'b0;
      hold_reg_q   <= '0;
      hold_valid_q <= 1'b0;
      word_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      miso_q       <= miso_d;
      hold_reg_q   <= hold_reg_d;
      hold_valid_q <= hold_valid_d;
      word_cnt_q   <= word_cnt_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
      ferr_q       <= ferr_d;
    end
  end

  assign spi_miso     = miso_q;
  assign spi_miso_oe  = ~cs_sync;
  assign fifo_wr_en   = push;
  assign fifo_wr_data = hold_reg_q;
  assign word_cnt     = word_cnt_q;
  assign frame_done   = frame_done_q;
  assign rx_overflow  = ovf_q;
  assign frame_err    = ferr_q;
  assign busy         = (state_q == SHIFT) || hold_valid_q;

endmodule

// File: tb/tb_spi_rx_framer.sv
// Directed bench for spi_rx_framer: table of full frames plus hand-written
// sequences for FIFO-full hold, overflow, framing error and mid-word reset.
module tb_spi_rx_framer;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] tx_word;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic [15:0] word_cnt;
  logic        frame_done, rx_overflow, frame_err;
  logic        err_clr;
  logic        busy;

  spi_rx_framer #(.WORD_W(16), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_word(tx_word), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .word_cnt(word_cnt), .frame_done(frame_done),
    .rx_overflow(rx_overflow), .frame_err(frame_err),
    .err_clr(err_clr), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Observed FIFO writes and frame_done pulses, sampled 1ns after the falling edge.
  logic [15:0] wr_q[$];
  int          wr_cyc = 0;
  int          fd_cnt = 0;

  always @(negedge PCLK) begin
    #1;
    if (fifo_wr_en) begin
      wr_q.push_back(fifo_wr_data);
      wr_cyc = cyc;
    end
    if (frame_done) fd_cnt = fd_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cs_start(input logic [15:0] txw);
    tx_word  = txw;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge PCLK);
  endtask

  // Mode 0: data changes with SCK low, master samples MISO just before each rise.
  task automatic shift_bits(input logic [15:0] w, input int n,
                            output logic [15:0] miso_w, output int rise_cyc);
    miso_w   = '0;
    rise_cyc = 0;
    for (int i = 0; i < n; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = w[15-i];
      repeat (4) @(negedge PCLK);
      miso_w   = {miso_w[14:0], spi_miso};
      spi_sck  = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(negedge PCLK);
    end
  endtask

  task automatic cs_end();
    spi_sck = 1'b0;
    repeat (4) @(negedge PCLK);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge PCLK);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    @(negedge PCLK);
  endtask

  function automatic logic [39:0] out_vec();
    return {spi_miso, spi_miso_oe, fifo_wr_en, fifo_wr_data, word_cnt,
            frame_done, rx_overflow, frame_err, busy};
  endfunction

  typedef struct {
    logic [15:0] mosi_w;
    logic [15:0] tx_w;
    logic [15:0] exp_data;
    logic [15:0] exp_miso;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] miso_w;
    int          rise_cyc;

    tbl[0] = '{mosi_w: 16'hA5C3, tx_w: 16'h8001, exp_data: 16'hA5C3, exp_miso: 16'h8001};
    tbl[1] = '{mosi_w: 16'h0000, tx_w: 16'hFFFF, exp_data: 16'h0000, exp_miso: 16'hFFFF};
    tbl[2] = '{mosi_w: 16'hFFFF, tx_w: 16'h0000, exp_data: 16'hFFFF, exp_miso: 16'h0000};
    tbl[3] = '{mosi_w: 16'h5A3C, tx_w: 16'h1234, exp_data: 16'h5A3C, exp_miso: 16'h1234};
    tbl[4] = '{mosi_w: 16'h0001, tx_w: 16'hC350, exp_data: 16'h0001, exp_miso: 16'hC350};

    PRESET    = 1'b1;
    spi_sck   = 1'b0;
    spi_cs_n  = 1'b1;
    spi_mosi  = 1'b0;
    tx_word   = 16'h0000;
    fifo_full = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("reset_outputs", {24'd0, out_vec()} , 64'd0);
    PRESET = 1'b0;
    repeat (4) @(negedge PCLK);
    chk("idle_outputs", {24'd0, out_vec()}, 64'd0);

    // Full frames, one word each, FIFO never full
    for (int v = 0; v < 5; v++) begin
      wr_q.delete();
      fd_cnt = 0;
      cs_start(tbl[v].tx_w);
      shift_bits(tbl[v].mosi_w, 16, miso_w, rise_cyc);
      chk($sformatf("v%0d_wr_count", v), wr_q.size(), 1);
      if (wr_q.size() > 0) chk($sformatf("v%0d_wr_data", v), wr_q[0], tbl[v].exp_data);
      chk($sformatf("v%0d_wr_latency", v), wr_cyc - rise_cyc, 3);
      chk($sformatf("v%0d_miso", v), miso_w, tbl[v].exp_miso);
      cs_end();
      chk($sformatf("v%0d_word_cnt", v), word_cnt, 1);
      chk($sformatf("v%0d_frame_done", v), fd_cnt, 1);
      chk($sformatf("v%0d_flags", v), {rx_overflow, frame_err, busy}, 3'b000);
    end

    // FIFO full during the word, released 40 PCLK after the last rise
    wr_q.delete();
    fifo_full = 1'b1;
    cs_start(16'h0000);
    shift_bits(16'h1234, 16, miso_w, rise_cyc);
    cs_end();
    repeat (24) @(negedge PCLK);
    chk("full_no_write", wr_q.size(), 0);
    chk("full_busy", busy, 1);
    chk("full_word_cnt", word_cnt, 0);
    fifo_full = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("full_write_count", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("full_write_data", wr_q[0], 16'h1234);
    chk("full_no_overflow", rx_overflow, 0);
    chk("full_word_cnt_after", word_cnt, 1);
    chk("full_busy_after", busy, 0);

    // Two words while full: second is lost, overflow flagged
    wr_q.delete();
    fifo_full = 1'b1;
    cs_start(16'h0000);
    shift_bits(16'h1111, 16, miso_w, rise_cyc);
    shift_bits(16'h2222, 16, miso_w, rise_cyc);
    cs_end();
    chk("ovf_flag", rx_overflow, 1);
    chk("ovf_no_write", wr_q.size(), 0);
    fifo_full = 1'b0;
    repeat (6) @(negedge PCLK);
    chk("ovf_write_count", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("ovf_write_data", wr_q[0], 16'h1111);
    chk("ovf_flag_sticky", rx_overflow, 1);
    pulse_err_clr();
    chk("ovf_cleared", rx_overflow, 0);

    // CS released after 7 bits: framing error, no write
    wr_q.delete();
    fd_cnt = 0;
    cs_start(16'h0000);
    shift_bits(16'hFFFF, 7, miso_w, rise_cyc);
    cs_end();
    chk("ferr_flag", frame_err, 1);
    chk("ferr_frame_done", fd_cnt, 1);
    chk("ferr_no_write", wr_q.size(), 0);
    chk("ferr_word_cnt", word_cnt, 0);
    pulse_err_clr();
    chk("ferr_cleared", frame_err, 0);

    // Reset in the middle of a word, then a clean frame
    cs_start(16'hFFFF);
    shift_bits(16'hFFFF, 9, miso_w, rise_cyc);
    PRESET   = 1'b1;
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    #1;
    chk("midreset_outputs", {24'd0, out_vec()}, 64'd0);
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (4) @(negedge PCLK);
    wr_q.delete();
    cs_start(16'h0000);
    shift_bits(16'hBEEF, 16, miso_w, rise_cyc);
    cs_end();
    chk("post_reset_count", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("post_reset_data", wr_q[0], 16'hBEEF);
    chk("post_reset_word_cnt", word_cnt, 1);
    chk("post_reset_ferr", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
